// File: rtl/rv_trace_encoder_if.sv
// APB configuration bus and packet stream towards the encapsulator.
interface rv_trace_encoder_if #(
    parameter int unsigned APB_ADDR_WIDTH = 32,
    parameter int unsigned N              = 1
);
    logic [APB_ADDR_WIDTH-1:0] paddr;
    logic                      pwrite;
    logic                      psel;
    logic                      penable;
    logic [31:0]               pwdata;
    logic                      pready;
    logic [31:0]               prdata;

    logic [N-1:0]              packet_valid;
    logic [N*2-1:0]            packet_type;
    logic [N*5-1:0]            packet_length;
    logic [N*128-1:0]          packet_payload;
    logic                      encapsulator_ready;

    // APB master that also sinks the packet stream.
    modport master (
        output paddr, pwrite, psel, penable, pwdata, encapsulator_ready,
        input  pready, prdata, packet_valid, packet_type, packet_length, packet_payload
    );

    // Trace encoder side.
    modport slave (
        input  paddr, pwrite, psel, penable, pwdata, encapsulator_ready,
        output pready, prdata, packet_valid, packet_type, packet_length, packet_payload
    );
endinterface

// File: rtl/rv_trace_encoder.sv
// Branch-trace instruction encoder: one retired block per cycle in, one packet register out.
module rv_trace_encoder #(
    parameter int unsigned N              = 1,
    parameter int unsigned ONLY_BRANCHES  = 1,
    parameter int unsigned APB_ADDR_WIDTH = 32
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic [N-1:0]      valid_i,
    input  logic [N*3-1:0]    itype_i,
    input  logic [31:0]       cause_i,
    input  logic [31:0]       tval_i,
    input  logic [1:0]        priv_i,
    input  logic [N*32-1:0]   iaddr_i,
    input  logic [N*32-1:0]   iretire_i,
    input  logic [N-1:0]      ilastsize_i,
    input  logic [63:0]       time_i,
    input  logic [31:0]       tvec_i,
    input  logic [31:0]       epc_i,
    output logic              stall_o,
    rv_trace_encoder_if.slave bus
);
    localparam logic [APB_ADDR_WIDTH-1:0] AddrCtrl   = APB_ADDR_WIDTH'(0);
    localparam logic [APB_ADDR_WIDTH-1:0] AddrStatus = APB_ADDR_WIDTH'(4);

    typedef enum logic [1:0] {FmtF0 = 2'd0, FmtF1 = 2'd1, FmtF2 = 2'd2, FmtF3 = 2'd3} fmt_e;

    if (N != 1 || ONLY_BRANCHES != 1) begin : g_unsupported
        $error("rv_trace_encoder supports only N=1 and ONLY_BRANCHES=1");
    end

    logic         enable_q, synced_q, synced_d, pend_q, pend_d;
    logic [30:0]  map_q, map_d;
    logic [4:0]   count_q, count_d;
    logic         pkt_valid_q;
    fmt_e         pkt_type_q;
    logic [4:0]   pkt_len_q;
    logic [127:0] pkt_payload_q;

    logic         emit;
    fmt_e         emit_type;
    logic [4:0]   emit_len;
    logic [127:0] emit_payload;

    logic [2:0]   itype;
    logic [31:0]  iaddr;
    logic         is_trap, is_branch, is_uninf, not_taken, not_taken_fmt, intr;
    logic         consume, apb_access, ctrl_wr;
    logic         unused_inputs;

    assign itype         = itype_i[2:0];
    assign iaddr         = iaddr_i[31:0];
    assign is_trap       = (itype == 3'd1) || (itype == 3'd2);
    assign intr          = (itype == 3'd2);
    assign is_branch     = (itype == 3'd4) || (itype == 3'd5);
    assign is_uninf      = (itype == 3'd3) || (itype == 3'd6);
    assign not_taken     = (itype == 3'd4);
    assign not_taken_fmt = ~(itype == 3'd5);

    assign stall_o    = pkt_valid_q & ~bus.encapsulator_ready;
    assign consume    = valid_i[0] & enable_q & ~stall_o;
    assign apb_access = bus.psel & bus.penable;
    assign ctrl_wr    = apb_access & bus.pwrite & (bus.paddr == AddrCtrl);

    assign bus.pready         = apb_access;
    assign bus.packet_valid   = pkt_valid_q;
    assign bus.packet_type    = pkt_type_q;
    assign bus.packet_length  = pkt_len_q;
    assign bus.packet_payload = pkt_payload_q;

    assign unused_inputs = ^{iretire_i, ilastsize_i, time_i, tvec_i, bus.pwdata[31:1]};

    // APB read mux, driven only during the access phase.
    always_comb begin
        bus.prdata = '0;
        if (apb_access) begin
            if (bus.paddr == AddrCtrl) begin
                bus.prdata = {31'b0, enable_q};
            end else if (bus.paddr == AddrStatus) begin
                bus.prdata = {26'b0, count_q, pkt_valid_q};
            end
        end
    end

    // Per-block packet decision and branch-map bookkeeping, highest priority first.
    always_comb begin
        synced_d     = synced_q;
        pend_d       = pend_q;
        map_d        = map_q;
        count_d      = count_q;
        emit         = 1'b0;
        emit_type    = FmtF0;
        emit_len     = 5'd0;
        emit_payload = '0;
        if (consume) begin
            if (!synced_q) begin
                emit               = 1'b1;
                emit_type          = FmtF3;
                emit_len           = 5'd5;
                emit_payload[38:0] = {iaddr, priv_i, not_taken_fmt, 2'b00, 2'b11};
                synced_d           = 1'b1;
                map_d              = '0;
                count_d            = '0;
            end else if (is_trap) begin
                emit                = 1'b1;
                emit_type           = FmtF3;
                emit_len            = 5'd13;
                emit_payload[103:0] = {tval_i, epc_i, intr, cause_i, priv_i, not_taken_fmt,
                                       2'b01, 2'b11};
                map_d               = '0;
                count_d             = '0;
                pend_d              = 1'b0;
            end else if (pend_q) begin
                emit = 1'b1;
                if (count_q == 5'd0) begin
                    emit_type          = FmtF2;
                    emit_len           = 5'd5;
                    emit_payload[33:0] = {iaddr, 2'b10};
                end else begin
                    emit_type          = FmtF1;
                    emit_len           = 5'd9;
                    emit_payload[69:0] = {iaddr, map_q, count_q, 2'b01};
                end
                pend_d  = 1'b0;
                map_d   = '0;
                count_d = '0;
                // The resolving block's own branch opens the fresh map.
                if (is_branch) begin
                    map_d[0] = not_taken;
                    count_d  = 5'd1;
                end
            end else if (is_branch) begin
                map_d[count_q] = not_taken;
                if (count_q == 5'd30) begin
                    // Map is full: flush it without an address.
                    emit               = 1'b1;
                    emit_type          = FmtF1;
                    emit_len           = 5'd5;
                    emit_payload[37:0] = {map_d, 5'd0, 2'b01};
                    map_d              = '0;
                    count_d            = '0;
                end else begin
                    count_d = count_q + 5'd1;
                end
            end else if (is_uninf) begin
                pend_d = 1'b1;
            end
        end
        // Disabling drops all trace context.
        if (ctrl_wr && !bus.pwdata[0]) begin
            synced_d = 1'b0;
            pend_d   = 1'b0;
            map_d    = '0;
            count_d  = '0;
        end
    end

    // Control and trace-context state.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            enable_q <= 1'b0;
            synced_q <= 1'b0;
            pend_q   <= 1'b0;
            map_q    <= '0;
            count_q  <= '0;
        end else begin
            if (ctrl_wr) begin
                enable_q <= bus.pwdata[0];
            end
            synced_q <= synced_d;
            pend_q   <= pend_d;
            map_q    <= map_d;
            count_q  <= count_d;
        end
    end

    // Single-entry packet register: load on emit, clear once the encapsulator takes it.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            pkt_valid_q   <= 1'b0;
            pkt_type_q    <= FmtF0;
            pkt_len_q     <= '0;
            pkt_payload_q <= '0;
        end else if (emit) begin
            pkt_valid_q   <= 1'b1;
            pkt_type_q    <= emit_type;
            pkt_len_q     <= emit_len;
            pkt_payload_q <= emit_payload;
        end else if (bus.encapsulator_ready) begin
            pkt_valid_q   <= 1'b0;
            pkt_type_q    <= FmtF0;
            pkt_len_q     <= '0;
            pkt_payload_q <= '0;
        end
    end
endmodule

// File: tb/tb_rv_trace_encoder.sv
// Directed bench for rv_trace_encoder.
module tb_rv_trace_encoder;
    logic        clk = 1'b0;
    logic        rst;
    logic        valid;
    logic [2:0]  itype;
    logic [31:0] cause, tval, iaddr, iretire, tvec, epc;
    logic [1:0]  priv;
    logic        ilastsize;
    logic [63:0] time_v;
    logic        stall;
    logic [31:0] rd;
    int          checks   = 0;
    int          failures = 0;

    always #5 clk = ~clk;

    rv_trace_encoder_if #(.APB_ADDR_WIDTH(32), .N(1)) bus ();

    rv_trace_encoder #(.N(1), .ONLY_BRANCHES(1), .APB_ADDR_WIDTH(32)) dut (
        .clk_i       (clk),
        .rst_i       (rst),
        .valid_i     (valid),
        .itype_i     (itype),
        .cause_i     (cause),
        .tval_i      (tval),
        .priv_i      (priv),
        .iaddr_i     (iaddr),
        .iretire_i   (iretire),
        .ilastsize_i (ilastsize),
        .time_i      (time_v),
        .tvec_i      (tvec),
        .epc_i       (epc),
        .stall_o     (stall),
        .bus         (bus)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_pkt(input string tag, input logic [1:0] typ, input logic [4:0] len,
                             input logic [127:0] payload);
        check({tag, "_valid"}, 128'(bus.packet_valid), 128'd1);
        check({tag, "_type"}, 128'(bus.packet_type), 128'(typ));
        check({tag, "_len"}, 128'(bus.packet_length), 128'(len));
        check({tag, "_payload"}, bus.packet_payload, payload);
    endtask

    task automatic apb_write(input logic [31:0] addr, input logic [31:0] data);
        bus.paddr   = addr;
        bus.pwdata  = data;
        bus.pwrite  = 1'b1;
        bus.psel    = 1'b1;
        bus.penable = 1'b0;
        tick();
        bus.penable = 1'b1;
        #1;
        check("pready_wr", 128'(bus.pready), 128'd1);
        tick();
        bus.psel    = 1'b0;
        bus.penable = 1'b0;
        bus.pwrite  = 1'b0;
    endtask

    task automatic apb_read(input logic [31:0] addr, output logic [31:0] data);
        bus.paddr   = addr;
        bus.pwrite  = 1'b0;
        bus.psel    = 1'b1;
        bus.penable = 1'b0;
        #1;
        check("prdata_setup_zero", 128'(bus.prdata), 128'd0);
        tick();
        bus.penable = 1'b1;
        #1;
        check("pready_rd", 128'(bus.pready), 128'd1);
        data = bus.prdata;
        tick();
        bus.psel    = 1'b0;
        bus.penable = 1'b0;
    endtask

    task automatic block(input logic [2:0] t, input logic [31:0] a);
        itype = t;
        iaddr = a;
        valid = 1'b1;
        tick();
        valid = 1'b0;
    endtask

    initial begin
        rst = 1'b1; valid = 1'b0; itype = '0; cause = '0; tval = '0; iaddr = '0;
        iretire = '0; tvec = '0; epc = '0; priv = '0; ilastsize = 1'b0; time_v = '0;
        bus.paddr = '0; bus.pwrite = 1'b0; bus.psel = 1'b0; bus.penable = 1'b0;
        bus.pwdata = '0; bus.encapsulator_ready = 1'b1;
        tick();
        tick();
        rst = 1'b0;

        // Reset state.
        check("rst_pkt_valid", 128'(bus.packet_valid), 128'd0);
        check("rst_payload", bus.packet_payload, 128'd0);
        check("rst_stall", 128'(stall), 128'd0);
        check("rst_pready", 128'(bus.pready), 128'd0);
        check("rst_prdata", 128'(bus.prdata), 128'd0);
        apb_read(32'h0, rd);
        check("rst_ctrl", 128'(rd), 128'd0);

        // Disabled: no packet.
        priv = 2'd3;
        block(3'd0, 32'h8000_0000);
        check("disabled_no_pkt", 128'(bus.packet_valid), 128'd0);

        // Enable, then start packet.
        apb_write(32'h0, 32'h1);
        apb_read(32'h0, rd);
        check("ctrl_enabled", 128'(rd), 128'd1);
        block(3'd0, 32'h8000_0000);
        // addr<<7 | priv 3<<5 | bit4=1 | 2'b11
        check_pkt("f3_start", 2'd3, 5'd5, 128'h40_0000_0073);
        check("f3_start_stall", 128'(stall), 128'd0);
        tick();
        check("f3_start_cleared", 128'(bus.packet_valid), 128'd0);

        // NT,T,NT then uninferable jump, resolved by 0x1000 -> F1 with address.
        block(3'd4, 32'h10);
        block(3'd5, 32'h14);
        block(3'd4, 32'h18);
        apb_read(32'h4, rd);
        check("status_count3", 128'(rd), 128'd6);
        block(3'd6, 32'h1c);
        block(3'd0, 32'h1000);
        // 0x1000<<38 | map 3'b101<<7 | count 3<<2 | 1
        check_pkt("f1_addr", 2'd1, 5'd9, 128'h4_0000_0000_028D);

        // Jump without branches -> F2.
        block(3'd6, 32'h20);
        block(3'd0, 32'h2000);
        check_pkt("f2", 2'd2, 5'd5, 128'h8002);

        // 31 taken branches -> F1 full on the 31st.
        for (int i = 0; i < 31; i++) begin
            block(3'd5, 32'h100 + 32'(i));
            if (i == 29) begin
                check("f1_full_not_yet", 128'(bus.packet_valid), 128'd0);
            end
        end
        check_pkt("f1_full", 2'd1, 5'd5, 128'h1);
        apb_read(32'h4, rd);
        check("status_after_full", 128'(rd), 128'd0);

        // Interrupt trap.
        cause = 32'd7; epc = 32'h400; tval = 32'h0; priv = 2'd3;
        block(3'd2, 32'h500);
        check_pkt("f3_trap_irq", 2'd3, 5'd13, 128'h4_0080_0000_03F7);

        // Exception trap with tval.
        cause = 32'd2; epc = 32'h88; tval = 32'hDEAD_BEEF; priv = 2'd0;
        block(3'd1, 32'h600);
        check_pkt("f3_trap_exc", 2'd3, 5'd13,
                  (128'hDEAD_BEEF << 72) | (128'h88 << 40) | (128'h2 << 7) | 128'h17);

        // Backpressure: packet held, stalled block consumed once ready returns.
        priv = 2'd3;
        block(3'd6, 32'h30);
        bus.encapsulator_ready = 1'b0;
        itype = 3'd0; iaddr = 32'h3000; valid = 1'b1;
        tick();
        check_pkt("stall_f2", 2'd2, 5'd5, 128'hC002);
        check("stall_high", 128'(stall), 128'd1);
        itype = 3'd1; cause = 32'd5; epc = 32'h500; tval = 32'h0;
        tick();
        check("stall_still", 128'(stall), 128'd1);
        check("stall_payload_held", bus.packet_payload, 128'hC002);
        apb_read(32'h4, rd);
        check("status_pkt_valid", 128'(rd), 128'd1);
        check("stall_payload_held2", bus.packet_payload, 128'hC002);
        bus.encapsulator_ready = 1'b1;
        #1;
        check("stall_released", 128'(stall), 128'd0);
        tick();
        valid = 1'b0;
        check_pkt("held_trap", 2'd3, 5'd13, (128'h500 << 40) | 128'h2F7);
        tick();
        check("held_trap_cleared", 128'(bus.packet_valid), 128'd0);

        // Disable clears context; re-enable resyncs with a start packet.
        block(3'd4, 32'h40);
        block(3'd4, 32'h44);
        apb_write(32'h0, 32'h0);
        apb_read(32'h4, rd);
        check("status_disabled", 128'(rd), 128'd0);
        block(3'd0, 32'h9000);
        check("disabled_again_no_pkt", 128'(bus.packet_valid), 128'd0);
        apb_write(32'h0, 32'h1);
        priv = 2'd1;
        block(3'd5, 32'h44);
        // 0x44<<7 | priv 1<<5 | bit4=0 (taken) | 2'b11
        check_pkt("resync_start", 2'd3, 5'd5, 128'h2223);
        apb_read(32'h4, rd);
        check("start_branch_dropped", 128'(rd), 128'd0);

        // Unmapped addresses.
        apb_read(32'h8, rd);
        check("unmapped_read", 128'(rd), 128'd0);
        apb_write(32'hC, 32'h0);
        apb_read(32'h0, rd);
        check("unmapped_write_ignored", 128'(rd), 128'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
